// File: rtl/vic_pkg.sv
// Shared definitions for the VIC interrupt responder: FSM encoding,
// VIC register map constants, entry vectors and bus widths.
package vic_pkg;

    localparam int BUS_W = 32;
    localparam int VEC_W = 32;

    localparam logic [BUS_W-1:0] VIC_BASE_DEF     = 32'hFFFF_F000;
    localparam logic [BUS_W-1:0] VECTADDR_OFS_DEF = 32'h0000_0030;
    localparam logic [VEC_W-1:0] FIQ_VECTOR_DEF   = 32'h0000_001C;
    localparam logic [VEC_W-1:0] IRQ_DEFAULT_DEF  = 32'h0000_0018;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BND = 3'd1,
        ST_VREAD    = 3'd2,
        ST_PRESENT  = 3'd3,
        ST_HOLDOFF  = 3'd4
    } vic_state_t;

endpackage

// File: rtl/vic_sync.sv
// Multi-flop synchronizer for one asynchronous request line.
module vic_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the raw request through the chain; the last flop is the clean copy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_chain <= '0;
        else          r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/vic_int_responder.sv
// CPU-side responder for the VIC FIQ/IRQ request lines. Requests are
// synchronized and masked by CPSR F/I, then taken at an instruction
// boundary. FIQ uses a fixed vector; IRQ fetches VICVectAddr over the bus.
// The chosen entry is handed to the fetch unit via EntryValid/EntryAccept.
module vic_int_responder
    import vic_pkg::*;
#(
    parameter int                 SYNC_STAGES  = 2,
    parameter logic [BUS_W-1:0]   VIC_BASE     = VIC_BASE_DEF,
    parameter logic [BUS_W-1:0]   VECTADDR_OFS = VECTADDR_OFS_DEF,
    parameter logic [VEC_W-1:0]   FIQ_VECTOR   = FIQ_VECTOR_DEF,
    parameter logic [VEC_W-1:0]   IRQ_DEFAULT  = IRQ_DEFAULT_DEF,
    parameter int                 TIMEOUT      = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             VICFIQRequest,
    input  logic             VICIRQRequest,
    input  logic             CPSR_F,
    input  logic             CPSR_I,
    input  logic             InstrBoundary,
    output logic             BusReq,
    output logic [BUS_W-1:0] BusAddr,
    input  logic [BUS_W-1:0] BusRData,
    input  logic             BusAck,
    input  logic             BusErr,
    output logic             EntryValid,
    output logic             EntryFIQ,
    output logic [VEC_W-1:0] EntryVector,
    input  logic             EntryAccept
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
    localparam logic [BUS_W-1:0] VECT_ADDR = VIC_BASE + VECTADDR_OFS;

    logic w_fiq_s, w_irq_s;
    logic w_fiq_q, w_irq_q, w_req, w_decide;

    vic_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fiq (
        .i_clk(HCLK), .i_rst_n(HRESETn), .i_async(VICFIQRequest), .o_sync(w_fiq_s)
    );

    vic_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_irq (
        .i_clk(HCLK), .i_rst_n(HRESETn), .i_async(VICIRQRequest), .o_sync(w_irq_s)
    );

    assign w_fiq_q = w_fiq_s & ~CPSR_F;
    assign w_irq_q = w_irq_s & ~CPSR_I;
    assign w_req   = w_fiq_q | w_irq_q;

    vic_state_t       r_state;
    logic             r_bus_req;
    logic [BUS_W-1:0] r_bus_addr;
    logic             r_entry_valid;
    logic             r_entry_fiq;
    logic [VEC_W-1:0] r_entry_vec;
    logic [CNT_W-1:0] r_cnt;

    // A boundary decision is made when a boundary arrives while pending, or
    // when a fresh request coincides with the boundary in IDLE.
    assign w_decide = InstrBoundary &
                      (((r_state == ST_IDLE) & w_req) | (r_state == ST_WAIT_BND));

    // Main sequencer: boundary wait, vector read, present, post-accept holdoff.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state       <= ST_IDLE;
            r_bus_req     <= 1'b0;
            r_bus_addr    <= '0;
            r_entry_valid <= 1'b0;
            r_entry_fiq   <= 1'b0;
            r_entry_vec   <= '0;
            r_cnt         <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_WAIT_BND: begin
                    if (w_decide) begin
                        // FIQ re-evaluated here so it preempts a pending IRQ.
                        if (w_fiq_q) begin
                            r_state       <= ST_PRESENT;
                            r_entry_valid <= 1'b1;
                            r_entry_fiq   <= 1'b1;
                            r_entry_vec   <= FIQ_VECTOR;
                        end else if (w_irq_q) begin
                            r_state    <= ST_VREAD;
                            r_bus_req  <= 1'b1;
                            r_bus_addr <= VECT_ADDR;
                            r_cnt      <= '0;
                        end else begin
                            r_state <= ST_IDLE;  // spurious: request vanished
                        end
                    end else begin
                        r_state <= w_req ? ST_WAIT_BND : ST_IDLE;
                    end
                end
                ST_VREAD: begin
                    // A started read always completes; FIQ waits for HOLDOFF.
                    if (BusAck || (r_cnt == CNT_LAST)) begin
                        r_state       <= ST_PRESENT;
                        r_bus_req     <= 1'b0;
                        r_bus_addr    <= '0;
                        r_entry_valid <= 1'b1;
                        r_entry_fiq   <= 1'b0;
                        r_entry_vec   <= (BusAck && !BusErr) ? BusRData : IRQ_DEFAULT;
                    end else if (r_cnt != CNT_SAT) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (EntryAccept) begin
                        r_state       <= ST_HOLDOFF;
                        r_entry_valid <= 1'b0;
                    end
                end
                ST_HOLDOFF: r_state <= ST_IDLE;  // let the CPSR mask update land
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign BusReq      = r_bus_req;
    assign BusAddr     = r_bus_addr;
    assign EntryValid  = r_entry_valid;
    assign EntryFIQ    = r_entry_fiq;
    assign EntryVector = r_entry_vec;

endmodule

// File: tb/tb_vic_int_responder.sv
// Directed bench for vic_int_responder: a per-cycle vector table for the
// main flows plus hand-written sequences for bus error, timeout and reset.
module tb_vic_int_responder;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        VICFIQRequest, VICIRQRequest, CPSR_F, CPSR_I, InstrBoundary;
    logic        BusReq, BusAck, BusErr;
    logic [31:0] BusAddr, BusRData;
    logic        EntryValid, EntryFIQ, EntryAccept;
    logic [31:0] EntryVector;

    vic_int_responder dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .VICFIQRequest(VICFIQRequest), .VICIRQRequest(VICIRQRequest),
        .CPSR_F(CPSR_F), .CPSR_I(CPSR_I), .InstrBoundary(InstrBoundary),
        .BusReq(BusReq), .BusAddr(BusAddr), .BusRData(BusRData),
        .BusAck(BusAck), .BusErr(BusErr),
        .EntryValid(EntryValid), .EntryFIQ(EntryFIQ),
        .EntryVector(EntryVector), .EntryAccept(EntryAccept)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        fiq, irq, cf, ci, bnd, ack, err, acc;
        logic [31:0] rdata;
        logic        e_valid, e_busreq, chk_ent, e_fiq;
        logic [31:0] e_vec;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic add(input logic fiq, irq, cf, ci, bnd, ack, err, acc,
                       input logic [31:0] rdata,
                       input logic ev, eb, ce, ef, input logic [31:0] evec);
        vec_t v;
        v.fiq = fiq; v.irq = irq; v.cf = cf; v.ci = ci; v.bnd = bnd;
        v.ack = ack; v.err = err; v.acc = acc; v.rdata = rdata;
        v.e_valid = ev; v.e_busreq = eb; v.chk_ent = ce; v.e_fiq = ef; v.e_vec = evec;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        VICFIQRequest = 0; VICIRQRequest = 0; CPSR_F = 0; CPSR_I = 0;
        InstrBoundary = 0; BusAck = 0; BusErr = 0; EntryAccept = 0; BusRData = '0;
    endtask

    task automatic tick();
        @(posedge HCLK); #1;
    endtask

    // Raise IRQ, let it synchronize, take it at a boundary; ends in VREAD.
    task automatic enter_vread(input string tag);
        VICIRQRequest = 1; tick(); tick();
        InstrBoundary = 1; tick();
        InstrBoundary = 0; VICIRQRequest = 0;
        chk({tag, "_busreq"}, 32'(BusReq), 32'd1);
        chk({tag, "_addr"}, BusAddr, 32'hFFFF_F030);
    endtask

    initial begin
        int n;
        idle_inputs();
        HRESETn = 0;
        tick(); tick();
        chk("rst_busreq", 32'(BusReq), 32'd0);
        chk("rst_valid",  32'(EntryValid), 32'd0);
        chk("rst_fiq",    32'(EntryFIQ), 32'd0);
        chk("rst_addr",   BusAddr, 32'd0);
        chk("rst_vec",    EntryVector, 32'd0);
        HRESETn = 1;
        tick();

        //  fiq irq cf ci bnd ack err acc rdata          ev eb ce ef vec
        // FIQ taken, boundary 5 cycles after the pin rises
        add(1,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(1,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(1,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(1,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(1,0,0,0,1,0,0,0,32'h0,          1,0,1,1,32'h1C);
        add(0,0,0,0,0,0,0,0,32'h0,          1,0,1,1,32'h1C);
        add(0,0,0,0,0,0,0,1,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        // IRQ vector read, ack in third VREAD cycle, then a stray late ack
        add(0,1,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,1,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,1,0,0,1,0,0,0,32'h0,          0,1,0,0,32'h0);
        add(0,1,0,0,0,0,0,0,32'h0,          0,1,0,0,32'h0);
        add(0,0,0,0,0,0,0,0,32'h0,          0,1,0,0,32'h0);
        add(0,0,0,0,0,1,0,0,32'h0000_8040,  1,0,1,0,32'h0000_8040);
        add(0,0,0,0,0,0,0,1,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,0,0,1,0,0,32'hDEAD_BEEF,  0,0,0,0,32'h0);
        add(0,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        // FIQ arrives while IRQ waits for the boundary and wins
        add(0,1,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,1,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(1,1,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(1,1,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(1,1,0,0,1,0,0,0,32'h0,          1,0,1,1,32'h1C);
        add(0,0,0,0,0,0,0,1,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        // FIQ masked by CPSR_F across two boundaries
        add(1,0,1,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(1,0,1,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(1,0,1,0,1,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(1,0,1,0,1,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,0,1,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,0,1,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        // IRQ withdrawn before the boundary: spurious, no read
        add(0,1,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,1,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,1,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,0,1,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        // IRQ masked by CPSR_I at the boundary
        add(0,1,0,1,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,1,0,1,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,1,0,1,1,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,1,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,1,0,0,0,0,32'h0,          0,0,0,0,32'h0);
        add(0,0,0,0,0,0,0,0,32'h0,          0,0,0,0,32'h0);

        foreach (tbl[i]) begin
            VICFIQRequest = tbl[i].fiq; VICIRQRequest = tbl[i].irq;
            CPSR_F = tbl[i].cf; CPSR_I = tbl[i].ci; InstrBoundary = tbl[i].bnd;
            BusAck = tbl[i].ack; BusErr = tbl[i].err; EntryAccept = tbl[i].acc;
            BusRData = tbl[i].rdata;
            tick();
            chk($sformatf("row%0d_valid", i), 32'(EntryValid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d_busreq", i), 32'(BusReq), 32'(tbl[i].e_busreq));
            if (tbl[i].e_busreq)
                chk($sformatf("row%0d_addr", i), BusAddr, 32'hFFFF_F030);
            if (tbl[i].chk_ent) begin
                chk($sformatf("row%0d_fiq", i), 32'(EntryFIQ), 32'(tbl[i].e_fiq));
                chk($sformatf("row%0d_vec", i), EntryVector, tbl[i].e_vec);
            end
        end
        idle_inputs();

        // Bus error on the vector read falls back to the default IRQ entry
        enter_vread("err");
        tick();
        BusAck = 1; BusErr = 1; BusRData = 32'h1234_5678;
        tick();
        BusAck = 0; BusErr = 0;
        chk("err_valid",  32'(EntryValid), 32'd1);
        chk("err_fiq",    32'(EntryFIQ), 32'd0);
        chk("err_vec",    EntryVector, 32'h18);
        chk("err_busreq", 32'(BusReq), 32'd0);
        EntryAccept = 1; tick(); EntryAccept = 0;
        chk("err_accept", 32'(EntryValid), 32'd0);
        tick(); tick();

        // No ack at all: BusReq holds for exactly TIMEOUT cycles
        enter_vread("to");
        n = 1;
        while (BusReq && n < 40) begin
            tick();
            if (BusReq) n++;
        end
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_valid",  32'(EntryValid), 32'd1);
        chk("to_vec",    EntryVector, 32'h18);
        chk("to_fiq",    32'(EntryFIQ), 32'd0);
        EntryAccept = 1; tick(); EntryAccept = 0;
        tick(); tick();

        // Reset during VREAD drops BusReq without a clock; late ack ignored
        enter_vread("rst");
        tick();
        #2 HRESETn = 0;
        #1;
        chk("rst_mid_busreq", 32'(BusReq), 32'd0);
        chk("rst_mid_addr",   BusAddr, 32'd0);
        chk("rst_mid_valid",  32'(EntryValid), 32'd0);
        tick();
        HRESETn = 1;
        BusAck = 1; BusRData = 32'h0000_ABCD;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("late_ack%0d_valid", k), 32'(EntryValid), 32'd0);
            chk($sformatf("late_ack%0d_busreq", k), 32'(BusReq), 32'd0);
        end
        BusAck = 0;
        chk("late_ack_vec", EntryVector, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
